// File: rtl/m_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : m_dmem_resp
// Description : Data-memory responder for the CPU load/store path. Accepts
//               one request at a time on a valid/ready request channel,
//               performs a byte/half/word access into a word-organised
//               array after a fixed latency, and returns load data or store
//               completion on a valid/ready response channel.
//
// Parameters  : ADDR_W      - byte-address bits decoded (2^(ADDR_W-2) words)
//               LATENCY     - accept edge to w_resp_valid high, 1..15 cycles
//               TOHOST_ADDR - byte address of the tohost MMIO word
//
// Optional    : DMEM_TOHOST_EN - when defined, a word store to TOHOST_ADDR
//               updates w_tohost instead of memory, word loads of that
//               address return w_tohost, and any non-word access to that
//               word faults. When undefined, w_tohost is tied to zero and
//               TOHOST_ADDR is ordinary memory.
//
// Ports       : w_clk          in   clock, all state on posedge
//               w_rst_n        in   synchronous active-low reset
//               w_req_valid    in   request present
//               w_req_ready    out  responder can accept (IDLE, not in reset)
//               w_req_we       in   1 = store, 0 = load
//               w_req_funct3   in   RV32I size/sign (B,H,W,BU,HU)
//               w_req_addr     in   byte address
//               w_req_wdata    in   store data, right-aligned
//               w_resp_valid   out  response present
//               w_resp_ready   in   initiator accepts response
//               w_resp_rdata   out  load result, 0 for stores/faults
//               w_resp_err     out  access fault
//               w_tohost       out  last value stored to TOHOST_ADDR
//
// Revision    : 1.0 - initial release
// ============================================================================
module m_dmem_resp #(
    parameter int          ADDR_W      = 8,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_00FC
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_req_valid,
    output logic        w_req_ready,
    input  logic        w_req_we,
    input  logic [2:0]  w_req_funct3,
    input  logic [31:0] w_req_addr,
    input  logic [31:0] w_req_wdata,
    output logic        w_resp_valid,
    input  logic        w_resp_ready,
    output logic [31:0] w_resp_rdata,
    output logic        w_resp_err,
    output logic [31:0] w_tohost
);

    localparam int         c_DEPTH    = 1 << (ADDR_W - 2);
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);
    localparam bit         c_DIRECT   = (LATENCY == 1);
`ifdef DMEM_TOHOST_EN
    localparam bit         c_TOHOST_EN = 1'b1;
`else
    localparam bit         c_TOHOST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } t_state;

    t_state             r_state;
    t_state             w_state_nxt;
    logic [3:0]         r_cnt;

    // Request captured at accept; inputs are don't-care after that.
    logic               r_we;
    logic [2:0]         r_funct3;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;

    logic [31:0]        r_rdata;
    logic               r_err;

    // Storage has no reset; contents survive w_rst_n.
    logic [31:0]        mem [0:c_DEPTH-1];

    logic               w_accept;
    logic               w_do_access;

    // Operands of the access actually being performed this cycle.
    logic               w_op_we;
    logic [2:0]         w_op_funct3;
    logic [31:0]        w_op_addr;
    logic [31:0]        w_op_wdata;

    logic [1:0]         w_off;
    logic [ADDR_W-3:0]  w_idx;
    logic [31:0]        w_word;
    logic               w_bad_f3;
    logic               w_misal;
    logic               w_oor;
    logic               w_th_hit;
    logic               w_acc_err;
    logic [3:0]         w_be;
    logic [31:0]        w_lane_mask;
    logic [31:0]        w_st_data;
    logic [31:0]        w_merged;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_ld_data;
    logic [31:0]        w_acc_rdata;
    logic               w_mem_wr;

    // ------------------------------------------------------------------
    // Handshake and outputs
    // ------------------------------------------------------------------
    assign w_req_ready  = w_rst_n && (r_state == S_IDLE);
    assign w_accept     = w_req_valid && w_req_ready;
    assign w_resp_valid = (r_state == S_RESP);
    assign w_resp_rdata = r_rdata;
    assign w_resp_err   = r_err;

    // With a one-cycle latency the access happens on the accept edge, so
    // it must use the live request; otherwise it uses the captured copy.
    generate
        if (LATENCY == 1) begin : g_op_direct
            assign w_op_we     = w_req_we;
            assign w_op_funct3 = w_req_funct3;
            assign w_op_addr   = w_req_addr;
            assign w_op_wdata  = w_req_wdata;
        end else begin : g_op_latched
            assign w_op_we     = r_we;
            assign w_op_funct3 = r_funct3;
            assign w_op_addr   = r_addr;
            assign w_op_wdata  = r_wdata;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign w_off    = w_op_addr[1:0];
    assign w_idx    = w_op_addr[ADDR_W-1:2];
    assign w_word   = mem[w_idx];

    assign w_bad_f3 = (w_op_funct3 == 3'b011) || (w_op_funct3[2:1] == 2'b11);
    assign w_misal  = ((w_op_funct3[1:0] == 2'b01) && w_off[0]) ||
                      ((w_op_funct3[1:0] == 2'b10) && (w_off != 2'b00));
    assign w_oor    = |w_op_addr[31:ADDR_W];
    // Constant-folds to zero when the tohost window is not built in.
    assign w_th_hit = c_TOHOST_EN && (w_op_addr[31:2] == TOHOST_ADDR[31:2]);
    assign w_acc_err = w_bad_f3 || w_misal || w_oor ||
                       (w_th_hit && (w_op_funct3 != 3'b010));

    // Store lanes: replicate the right-aligned data into every lane and let
    // the byte enables pick which lanes are merged into the old word.
    always_comb begin
        w_be      = 4'b0000;
        w_st_data = w_op_wdata;
        case (w_op_funct3[1:0])
            2'b00: begin
                w_be      = 4'b0001 << w_off;
                w_st_data = {4{w_op_wdata[7:0]}};
            end
            2'b01: begin
                w_be      = w_off[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{w_op_wdata[15:0]}};
            end
            default: begin
                w_be      = 4'b1111;
                w_st_data = w_op_wdata;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_mask[8*gi +: 8] = {8{w_be[gi]}};
        end
    endgenerate

    assign w_merged = (w_word & ~w_lane_mask) | (w_st_data & w_lane_mask);

    // Load extraction and extension.
    always_comb begin
        w_byte    = w_word[{w_off, 3'b000} +: 8];
        w_half    = w_off[1] ? w_word[31:16] : w_word[15:0];
        w_ld_data = 32'h0;
        case (w_op_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_data = {24'h0, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_data = {16'h0, w_half};
            3'b010:  w_ld_data = w_word;
            default: w_ld_data = 32'h0;
        endcase
    end

    always_comb begin
        w_acc_rdata = 32'h0;
        if (!w_acc_err && !w_op_we) begin
            w_acc_rdata = w_th_hit ? w_tohost : w_ld_data;
        end
    end

    // The reset term drops a store whose access edge coincides with reset.
    assign w_mem_wr = w_rst_n && w_do_access && w_op_we && !w_acc_err && !w_th_hit;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    // The counter is loaded with LATENCY-1 and the access is performed on
    // the edge where it would reach zero, so the response becomes visible
    // exactly LATENCY cycles after the accept edge.
    always_comb begin
        w_state_nxt = r_state;
        w_do_access = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (c_DIRECT) begin
                        w_state_nxt = S_RESP;
                        w_do_access = 1'b1;
                    end else begin
                        w_state_nxt = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                    w_do_access = 1'b1;
                end
            end
            S_RESP: begin
                if (w_resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we     <= w_req_we;
                r_funct3 <= w_req_funct3;
                r_addr   <= w_req_addr;
                r_wdata  <= w_req_wdata;
                r_cnt    <= c_CNT_INIT;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_do_access) begin
                r_rdata <= w_acc_rdata;
                r_err   <= w_acc_err;
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_mem_wr) begin
            mem[w_idx] <= w_merged;
        end
    end

`ifdef DMEM_TOHOST_EN
    logic        w_th_wr;
    logic [31:0] r_tohost;

    assign w_th_wr = w_do_access && w_op_we && !w_acc_err && w_th_hit;

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_tohost <= 32'h0;
        end else if (w_th_wr) begin
            r_tohost <= w_op_wdata;
        end
    end

    assign w_tohost = r_tohost;
`else
    assign w_tohost = 32'h0;
`endif

endmodule
`default_nettype wire
